// File: rtl/mem_access.sv
// Memory stage of the pipeline: holds one instruction, talks to the data memory,
// formats load data and hands the finished instruction to WB.
module mem_access (
    input  logic         clk,
    input  logic         reset,
    input  logic         EXE_over,
    input  logic [153:0] EXE_MEM_bus_r,
    input  logic         WB_allowin,
    input  logic         cancel,
    output logic         MEM_allowin,
    output logic         WB_valid,
    output logic [117:0] MEM_WB_bus_r,
    output logic [4:0]   MEM_wdest,
    output logic         dm_req,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_addr,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

    state_t         state_q;
    logic [153:0]   bus_q;
    logic           memValid_q;
    logic [31:0]    loadData_q;
    logic           wbValid_q;
    logic [117:0]   wbBus_q;

    logic           isLd, isSt, isByte, isSgn, inMemOp;
    logic [31:0]    storeData, exeResult, loadFmt, memResult;
    logic [1:0]     lane;
    logic [7:0]     rdByte;
    logic           memOver, capture, transfer;
    logic [117:0]   wbBus_d;

    assign isLd      = bus_q[153];
    assign isSt      = bus_q[152];
    assign isByte    = bus_q[151];
    assign isSgn     = bus_q[150];
    assign storeData = bus_q[149:118];
    assign exeResult = bus_q[111:80];
    assign lane      = exeResult[1:0];
    assign inMemOp   = EXE_MEM_bus_r[153] | EXE_MEM_bus_r[152];

    // Byte lanes are little-endian: lane 0 is dm_rdata[7:0].
    assign rdByte  = dm_rdata[{lane, 3'b000} +: 8];
    assign loadFmt = !isByte ? dm_rdata
                   : isSgn   ? {{24{rdByte[7]}}, rdByte}
                   :           {24'h0, rdByte};

    assign memOver     = memValid_q & (((!isLd & !isSt) & (state_q == IDLE)) | (state_q == DONE));
    assign MEM_allowin = (!memValid_q | (memOver & WB_allowin)) & (state_q != DRAIN);
    assign capture     = EXE_over & MEM_allowin & !cancel;
    assign transfer    = memOver & WB_allowin & !cancel;

    assign memResult = isLd ? loadData_q : exeResult;
    assign wbBus_d   = {bus_q[117:112], memResult, bus_q[79:0]};

    assign dm_req   = (state_q == REQ) | (state_q == DRAIN);
    assign dm_addr  = {exeResult[31:2], 2'b00};
    assign dm_wen   = !isSt ? 4'h0 : (isByte ? (4'b0001 << lane) : 4'hF);
    assign dm_wdata = isByte ? {4{storeData[7:0]}} : storeData;

    assign WB_valid     = wbValid_q;
    assign MEM_WB_bus_r = wbBus_q;
    assign MEM_wdest    = bus_q[116:112] & {5{memValid_q}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bus_q      <= '0;
            memValid_q <= 1'b0;
            loadData_q <= '0;
            wbValid_q  <= 1'b0;
            wbBus_q    <= '0;
        end else begin
            if (cancel) begin
                memValid_q <= 1'b0;
                wbValid_q  <= 1'b0;
            end else begin
                if (capture) begin
                    bus_q      <= EXE_MEM_bus_r;
                    memValid_q <= 1'b1;
                end else if (transfer) begin
                    memValid_q <= 1'b0;
                end
                if (transfer) begin
                    wbBus_q   <= wbBus_d;
                    wbValid_q <= 1'b1;
                end else if (WB_allowin) begin
                    wbValid_q <= 1'b0;
                end
            end

            // A cancelled request still owns the bus until memory acknowledges it.
            case (state_q)
                IDLE, DONE: begin
                    if (cancel)
                        state_q <= IDLE;
                    else if (capture && inMemOp)
                        state_q <= REQ;
                    else if (transfer)
                        state_q <= IDLE;
                end
                REQ: begin
                    if (dm_ack) begin
                        loadData_q <= loadFmt;
                        state_q    <= cancel ? IDLE : DONE;
                    end else if (cancel) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dm_ack)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
